// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and the
// bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The counter has to reach WIDTH, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor: d = x - y - bin, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, start/busy/done.
// Optional signed-overflow flag enabled by macro SERIAL_SUBTRACTOR_OVF_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; results held
// ST_SHIFT | one result bit per clock, WIDTH clocks
// ST_DONE  | done pulse, results valid
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bo_bit;
    logic             start_acc;
    logic             last_shift;

    full_subtractor u_fs (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (br),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    assign start_acc  = (state == ST_IDLE) && start;
    assign last_shift = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_SHIFT;
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        diff  <= '0;
                        bout  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= bo_bit;
                    cnt  <= cnt + CW'(1);
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    if (last_shift) begin
                        state <= ST_DONE;
                        bout  <= bo_bit;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;

    // The final diff bit is d_bit on the last shift edge, so ovf lands with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (start_acc) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            ovf   <= 1'b0;
        end else if (last_shift) begin
            ovf <= (a_msb != b_msb) & (d_bit != a_msb);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus
// random operands against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_diff(input int x, input int y);
        int r;
        r = x - y;
        return W'(r);
    endfunction

    function automatic logic ref_bout(input int x, input int y);
        return x < y;
    endfunction

    function automatic logic ref_ovf(input int x, input int y);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        int sx, sy, r;
        sx = (x >= 2**(W-1)) ? x - 2**W : x;
        sy = (y >= 2**(W-1)) ? y - 2**W : y;
        r  = sx - sy;
        return (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
`else
        return (x < 0) && (y < 0);
`endif
    endfunction

    // One full operation, called at a negedge with the DUT idle. A positive
    // inj_at pulses start with junk operands at that edge index during SHIFT.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input int inj_at);
        int          edges;
        int          guard;
        int          ndone;
        logic        busy_ok;
        logic [W-1:0] ed;
        guard = 0;
        while (busy && guard < 4 * W) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
        ed = ref_diff(int'(xa), int'(xb));
        a = xa; b = xb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        edges = 1;
        busy_ok = 1'b1;
        while (!done && edges < 3 * W) begin
            if (!busy) busy_ok = 1'b0;
            if (edges == inj_at) begin
                start = 1'b1; a = '1; b = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        chk("busy_in_shift", {31'd0, busy_ok}, 32'd1);
        chk("latency", edges, W + 1);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        chk("diff", {24'd0, diff}, {24'd0, ed});
        chk("bout", {31'd0, bout}, {31'd0, ref_bout(int'(xa), int'(xb))});
        chk("ovf", {31'd0, ovf}, {31'd0, ref_ovf(int'(xa), int'(xb))});
        @(negedge clk);
        chk("done_width", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("no_extra_done", ndone, 0);
        chk("diff_held", {24'd0, diff}, {24'd0, ed});
    endtask

    initial begin
        int first, second, nd;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {20'd0, busy, done, diff, bout, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h50, 8'h20, -1);
        run_op(8'h20, 8'h50, -1);
        run_op(8'h80, 8'h01, -1);
        run_op(8'h00, 8'hFF, -1);
        run_op(8'h3C, 8'h3C, -1);
        run_op(8'h7F, 8'h80, -1);
        run_op(8'h11, 8'h22, 3);

        // abort mid-operation with count = 4
        a = 8'h9A; b = 8'h17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outs", {20'd0, busy, done, diff, bout, ovf}, 32'd0);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_op(8'h9A, 8'h17, -1);

        // start held high: back-to-back operations
        a = 8'hC3; b = 8'h5A; start = 1'b1;
        first = -1; second = -1;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (done) begin
                chk("b2b_diff", {24'd0, diff}, {24'd0, ref_diff(32'hC3, 32'h5A)});
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        start = 1'b0;
        chk("b2b_period", second - first, W + 2);
        repeat (W + 3) @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (k % 8 == 0) rb = ra;
            run_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W - 1)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
